// File: rtl/fifo_wr_ptr_ctrl_pkg.sv
// Shared types, default sizes and Gray-code helpers for the async FIFO pointer path.
// The helpers work on a wide fixed-width code. Callers zero-extend the value
// on the way in and truncate it on the way out. The upper zeros have no effect
// on either conversion, so one function pair serves every pointer width.
package fifo_wr_ptr_ctrl_pkg;

  typedef logic bit_t;

  localparam int ADDR_W = 4;           // RAM address bits
  localparam int PTR_W  = ADDR_W + 1;  // pointer bits (one wrap bit)
  localparam int CODE_W = 32;          // working width of the helper functions

  // Binary to reflected Gray code
  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it
  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b = {CODE_W{1'b0}};
    for (int i = 0; i < CODE_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// Write-side FIFO pointer bus.
// master: the writer/environment. It drives wr_en and the synchronized read pointer.
// slave : the pointer controller. It drives the RAM address/enable, the Gray pointer and the status flags.
interface fifo_wr_ptr_ctrl_if
  import fifo_wr_ptr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W
);
  bit_t                  wr_en;
  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync;
  logic [ADDR_WIDTH-1:0] wr_addr;
  bit_t                  mem_we;
  logic [ADDR_WIDTH:0]   wr_ptr_gray;
  bit_t                  full;
  bit_t                  almost_full;
  logic [ADDR_WIDTH:0]   level;
  bit_t                  overflow;

  modport master (
    output wr_en, rd_ptr_gray_sync,
    input  wr_addr, mem_we, wr_ptr_gray, full, almost_full, level, overflow
  );

  modport slave (
    input  wr_en, rd_ptr_gray_sync,
    output wr_addr, mem_we, wr_ptr_gray, full, almost_full, level, overflow
  );
endinterface

// File: rtl/fifo_wr_ptr_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter. The read-side controller uses it as well.
// Ports: gray (in, WIDTH) -> bin (out, WIDTH).
module fifo_wr_ptr_ctrl_gray2bin
  import fifo_wr_ptr_ctrl_pkg::*;
#(
  parameter int WIDTH = PTR_W
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(CODE_W'(gray)));

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer controller of the async FIFO.
// It keeps the binary and Gray write pointers and drives the RAM write
// address and enable. It publishes a registered Gray pointer to the read domain.
// It derives full, almost_full, level and overflow from the synchronized read pointer.
// Ports:
//   clk                write-domain clock
//   reset              asynchronous, active-low reset
//   bus (slave)        wr_en, rd_ptr_gray_sync in
//                      wr_addr, mem_we, wr_ptr_gray, full, almost_full, level, overflow out
module fifo_wr_ptr_ctrl
  import fifo_wr_ptr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int AF_MARGIN  = 2
) (
  input  logic              clk,
  input  logic              reset,
  fifo_wr_ptr_ctrl_if.slave bus
);

  localparam int AW    = ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wgray_r;
  logic [PW-1:0] level_r;
  bit_t          full_r;
  bit_t          af_r;
  bit_t          ovf_r;

  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] rgray_full_s;
  logic [PW-1:0] level_next_s;
  bit_t          full_next_s;
  bit_t          af_next_s;
  bit_t          push_s;

  // Read pointer back to binary for the occupancy arithmetic
  fifo_wr_ptr_ctrl_gray2bin #(
    .WIDTH (PW)
  ) u_rd_gray2bin (
    .gray (bus.rd_ptr_gray_sync),
    .bin  (rbin_s)
  );

  // mem_we must read 0 while reset is held, even if wr_en is already high
  assign push_s = bus.wr_en & ~full_r & reset;

  // Next pointer and next status. Full means the write Gray pointer matches
  // the read Gray pointer with its two MSBs inverted, i.e. exactly DEPTH ahead.
  always_comb begin
    wbin_next_s  = wbin_r + {{AW{1'b0}}, push_s};
    wgray_next_s = PW'(bin2gray(CODE_W'(wbin_next_s)));
    rgray_full_s = {~bus.rd_ptr_gray_sync[AW:AW-1], bus.rd_ptr_gray_sync[AW-2:0]};
    full_next_s  = (wgray_next_s == rgray_full_s);
    level_next_s = wbin_next_s - rbin_s;
    af_next_s    = (level_next_s >= AF_THRESH);
  end

  // Pointer and status registers. Each crossing-domain output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbin_r  <= {PW{1'b0}};
      wgray_r <= {PW{1'b0}};
      level_r <= {PW{1'b0}};
      full_r  <= 1'b0;
      af_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      wbin_r  <= wbin_next_s;
      wgray_r <= wgray_next_s;
      level_r <= level_next_s;
      full_r  <= full_next_s;
      af_r    <= af_next_s;
      ovf_r   <= bus.wr_en & full_r;
    end
  end

  assign bus.wr_addr     = wbin_r[AW-1:0];
  assign bus.mem_we      = push_s;
  assign bus.wr_ptr_gray = wgray_r;
  assign bus.level       = level_r;
  assign bus.full        = full_r;
  assign bus.almost_full = af_r;
  assign bus.overflow    = ovf_r;

endmodule
